of_stage: RTL

- Operand-fetch stage of the scalar 12-bit pipeline; sits directly upstream of the ALU adder stage and produces its op_1/op_2 operand pair.
- Decodes a 12-bit instruction and reads an internal 8x12 register file.
- Forwards in-flight EX and WB results into the operands.
- Presents registered operands to the ALU through a valid/ready pipeline register.

---
 rtl/of_pkg.sv | 32 +++
 rtl/of_regfile.sv | 36 +++
 rtl/of_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/of_pkg.sv
// rtl/of_pkg.sv - shared widths, opcode constants and instruction field layout for the operand-fetch stage
package of_pkg;

  localparam int DW   = 12;
  localparam int NREG = 8;
  localparam int AW   = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam int OPC_LSB = 9;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 3;
  localparam int RS2_LSB = 0;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } instr_t;

  function automatic instr_t decode(input logic [DW-1:0] w);
    instr_t d;
    d.opcode = w[OPC_LSB +: 3];
    d.rd     = w[RD_LSB  +: AW];
    d.rs1    = w[RS1_LSB +: AW];
    d.rs2    = w[RS2_LSB +: AW];
    return d;
  endfunction

endpackage

// File: rtl/of_regfile.sv
// rtl/of_regfile.sv - 8x12 register file, R0 hardwired zero, two async read ports, one sync write port
module of_regfile
  import of_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/of_stage.sv
// rtl/of_stage.sv - operand fetch: decode, register read with EX/WB bypass, valid/ready output register
module of_stage
  import of_pkg::*;
#(
  parameter logic [2:0] IMM_OP = OP_ADDI
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] op_1,
  output logic [DW-1:0] op_2,
  output logic [2:0]    out_opcode,
  output logic [AW-1:0] out_rd,
  input  logic          ex_fwd_en,
  input  logic [AW-1:0] ex_fwd_addr,
  input  logic [DW-1:0] ex_fwd_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  instr_t        dec;
  logic [DW-1:0] rf_a, rf_b;
  logic [DW-1:0] src_1, src_2;
  logic          accept;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] op_1_q, op_1_d;
  logic [DW-1:0] op_2_q, op_2_d;
  logic [2:0]    opcode_q, opcode_d;
  logic [AW-1:0] rd_q, rd_d;

  assign dec = decode(in_instr);

  of_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (dec.rs1),
    .rdata_a (rf_a),
    .raddr_b (dec.rs2),
    .rdata_b (rf_b)
  );

  // EX result is younger than WB, so it wins; WB bypass covers the same-cycle write.
  function automatic logic [DW-1:0] resolve(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] rf_val,
    input logic          ex_en,
    input logic [AW-1:0] ex_addr,
    input logic [DW-1:0] ex_data,
    input logic          w_en,
    input logic [AW-1:0] w_addr,
    input logic [DW-1:0] w_data
  );
    if (addr == '0)                   return '0;
    else if (ex_en && ex_addr == addr) return ex_data;
    else if (w_en && w_addr == addr)   return w_data;
    else                               return rf_val;
  endfunction

  always_comb begin
    src_1 = resolve(dec.rs1, rf_a, ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);
    src_2 = resolve(dec.rs2, rf_b, ex_fwd_en, ex_fwd_addr, ex_fwd_data, wb_en, wb_addr, wb_data);
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op_1_d      = op_1_q;
    op_2_d      = op_2_q;
    opcode_d    = opcode_q;
    rd_d        = rd_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op_1_d      = src_1;
      op_2_d      = (dec.opcode == IMM_OP) ? {{(DW-AW){1'b0}}, dec.rs2} : src_2;
      opcode_d    = dec.opcode;
      rd_d        = dec.rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_1_q      <= '0;
      op_2_q      <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_1_q      <= op_1_d;
      op_2_q      <= op_2_d;
      opcode_q    <= opcode_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign op_1       = op_1_q;
  assign op_2       = op_2_q;
  assign out_opcode = opcode_q;
  assign out_rd     = rd_q;

endmodule
